// File: rtl/stream_width_down_pkg.sv
// Shared types for the wide-to-narrow stream serializer.
// The control flag is kept as a named two-state enum so waveforms read IDLE/SHIFT.
package stream_width_down_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/stream_width_down.sv
// Splits each wide input word into Ratio narrow slices, one slice per accepted beat.
// Next word is taken on the same edge as the final slice, so a held stream has no bubbles.
module stream_width_down
  import stream_width_down_pkg::*;
#(
  parameter int InWidth  = 32,
  parameter int OutWidth = 8,
  parameter bit MsbFirst = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [InWidth-1:0]  din_data,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [OutWidth-1:0] dout_data,
  output logic                dout_last
);

  localparam int Ratio   = InWidth / OutWidth;
  localparam int CntBits = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntBits-1:0] LastCnt = CntBits'(Ratio - 1);

  if (((InWidth % OutWidth) != 0) || (Ratio < 2)) begin : g_bad_ratio
    $error("stream_width_down: InWidth must be a multiple of OutWidth with at least two slices");
  end

  state_t               state;
  state_t               state_next;
  logic [InWidth-1:0]   sreg;
  logic [CntBits-1:0]   cnt;
  logic                 busy;
  logic                 word_fire;
  logic                 slice_fire;

  assign busy       = (state == SHIFT);
  assign word_fire  = din_valid & din_ready;
  assign slice_fire = dout_valid & dout_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Leaving SHIFT only when the last slice goes out with no replacement word behind it.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (word_fire) state_next = SHIFT;
      SHIFT: if (slice_fire && dout_last && !word_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // din_ready looks at dout_ready directly so the reload can share the last-slice edge.
  always_comb begin
    dout_valid = busy;
    dout_last  = busy && (cnt == LastCnt);
    din_ready  = !busy || (dout_ready && dout_last);
    dout_data  = MsbFirst ? sreg[InWidth-1 -: OutWidth] : sreg[OutWidth-1:0];
  end

  // The slice on display always sits at the output end, so a shift just exposes the next one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (word_fire) begin
      sreg <= din_data;
      cnt  <= '0;
    end else if (slice_fire && !dout_last) begin
      sreg <= MsbFirst ? (sreg << OutWidth) : (sreg >> OutWidth);
      cnt  <= cnt + CntBits'(1);
    end
  end

endmodule

// File: tb/tb_stream_width_down.sv
// Self-checking bench: MSB-first and LSB-first instances share one stimulus stream
// and are compared every cycle against a per-instance queue of expected slices.
module tb_stream_width_down;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_valid = 1'b0;
  logic [31:0] din_data = '0;
  logic        dout_ready = 1'b1;

  logic        din_ready_m, dout_valid_m, dout_last_m;
  logic [7:0]  dout_data_m;
  logic        din_ready_l, dout_valid_l, dout_last_l;
  logic [7:0]  dout_data_l;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cycle = 0;
  int          ready_mode = 0;
  bit          fresh = 1'b1;

  logic [7:0]  qm[$];
  logic [7:0]  ql[$];
  beat_t       log_m[$];
  beat_t       log_l[$];
  logic [31:0] sent[$];

  stream_width_down #(.InWidth(32), .OutWidth(8), .MsbFirst(1'b1)) dut_msb (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready_m), .din_data(din_data),
    .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .dout_data(dout_data_m), .dout_last(dout_last_m)
  );

  stream_width_down #(.InWidth(32), .OutWidth(8), .MsbFirst(1'b0)) dut_lsb (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready_l), .din_data(din_data),
    .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .dout_data(dout_data_l), .dout_last(dout_last_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: each word becomes four pending slices; the head is what must be on dout.
  always @(negedge clk) begin
    bit exp_ready;
    if (!rst) begin
      qm.delete();
      ql.delete();
      fresh = 1'b1;
    end else begin
      exp_ready = (qm.size() == 0) || (qm.size() == 1 && dout_ready);
      checkOutput("din_ready_msb", 32'(din_ready_m), 32'(exp_ready));
      checkOutput("din_ready_lsb", 32'(din_ready_l), 32'(exp_ready));
      checkOutput("dout_valid_msb", 32'(dout_valid_m), 32'(qm.size() != 0));
      checkOutput("dout_valid_lsb", 32'(dout_valid_l), 32'(ql.size() != 0));
      if (qm.size() != 0) begin
        checkOutput("dout_data_msb", 32'(dout_data_m), 32'(qm[0]));
        checkOutput("dout_last_msb", 32'(dout_last_m), 32'(qm.size() == 1));
      end else begin
        checkOutput("dout_last_msb_idle", 32'(dout_last_m), 32'd0);
        if (fresh) checkOutput("dout_data_msb_reset", 32'(dout_data_m), 32'd0);
      end
      if (ql.size() != 0) begin
        checkOutput("dout_data_lsb", 32'(dout_data_l), 32'(ql[0]));
        checkOutput("dout_last_lsb", 32'(dout_last_l), 32'(ql.size() == 1));
      end else begin
        checkOutput("dout_last_lsb_idle", 32'(dout_last_l), 32'd0);
        if (fresh) checkOutput("dout_data_lsb_reset", 32'(dout_data_l), 32'd0);
      end
      if (dout_valid_m && dout_ready) log_m.push_back('{dout_data_m, dout_last_m, cycle});
      if (dout_valid_l && dout_ready) log_l.push_back('{dout_data_l, dout_last_l, cycle});
      if (qm.size() != 0 && dout_ready) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (din_valid && exp_ready) begin
        for (int i = 0; i < 4; i++) begin
          qm.push_back(din_data[31 - 8*i -: 8]);
          ql.push_back(din_data[8*i +: 8]);
        end
        fresh = 1'b0;
      end
    end
  end

  // dout_ready source: 0 = held high, 1 = 1,0,0 pattern, 2 = coin flip each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       dout_ready = (cycle % 3) == 0;
        2:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b1;
      endcase
    end
  end

  task automatic applyStimulus(input logic [31:0] w);
    bit done = 1'b0;
    din_valid = 1'b1;
    din_data  = w;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      done = din_ready_m;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("word_accept_timeout", 32'd0, 32'd1);
    else sent.push_back(w);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 400 && !empty; i++) begin
      @(negedge clk);
      #1;
      empty = (qm.size() == 0);
    end
    if (!empty) checkOutput("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkLog(input string name, input beat_t lg[$], input logic [31:0] bytes);
    logic [31:0] b;
    b = bytes;
    checkOutput({name, "_count"}, 32'(lg.size()), 32'd4);
    for (int i = 0; i < 4 && i < lg.size(); i++) begin
      checkOutput({name, "_byte"}, 32'(lg[i].d), 32'(b[31 - 8*i -: 8]));
      checkOutput({name, "_last"}, 32'(lg[i].l), 32'(i == 3));
    end
  endtask

  initial begin
    rst = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dout_valid", 32'(dout_valid_m), 32'd0);
    checkOutput("rst_dout_last", 32'(dout_last_m), 32'd0);
    checkOutput("rst_dout_data", 32'(dout_data_m), 32'd0);
    checkOutput("rst_din_ready", 32'(din_ready_m), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    log_m.delete(); log_l.delete();
    applyStimulus(32'hA1B2C3D4);
    drain();
    checkLog("single_msb", log_m, 32'hA1B2C3D4);
    checkLog("single_lsb", log_l, 32'hD4C3B2A1);

    log_m.delete(); log_l.delete();
    applyStimulus(32'h01020304);
    applyStimulus(32'h05060708);
    drain();
    checkOutput("b2b_count", 32'(log_m.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_m.size(); i++) begin
      checkOutput("b2b_byte", 32'(log_m[i].d), 32'(i + 1));
      checkOutput("b2b_nobubble", 32'(log_m[i].cyc - log_m[0].cyc), 32'(i));
    end

    log_m.delete(); log_l.delete();
    ready_mode = 1;
    applyStimulus(32'hDEADBEEF);
    drain();
    ready_mode = 0;
    checkLog("bp_msb", log_m, 32'hDEADBEEF);

    log_m.delete(); log_l.delete();
    applyStimulus(32'h11223344);
    drain();
    checkLog("lsb_first", log_l, 32'h44332211);

    applyStimulus(32'hCAFEF00D);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midrst_valid", 32'(dout_valid_m), 32'd0);
    log_m.delete(); log_l.delete();
    sent.delete();
    @(posedge clk);
    #1;
    applyStimulus(32'h00000001);
    drain();
    checkLog("after_rst", log_m, 32'h00000001);

    log_m.delete(); log_l.delete();
    sent.delete();
    ready_mode = 2;
    for (int w = 0; w < 60; w++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus($urandom);
    end
    drain();
    ready_mode = 0;
    checkOutput("rand_bytes", 32'(log_m.size()), 32'(4 * sent.size()));
    begin
      int lasts = 0;
      for (int i = 0; i < log_m.size(); i++) begin
        lasts += int'(log_m[i].l);
        if (i / 4 < sent.size())
          checkOutput("rand_order", 32'(log_m[i].d), 32'(sent[i / 4][31 - 8*(i % 4) -: 8]));
      end
      checkOutput("rand_lasts", 32'(lasts), 32'(sent.size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
